// File: rtl/jtframe_ps2_tx_if.sv
// Purpose : host-side command handshake for the PS/2 host-to-device transmitter.
// Latency : n/a (signal bundle only).
// Backpressure: host must not expect tx_start to be taken while busy=1; it is dropped.
// Ports   : tx_data[7:0], tx_start (host -> tx); busy, done, error (tx -> host).
interface jtframe_ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_start, input busy, done, error);
  modport slave  (input tx_data, tx_start, output busy, done, error);
endinterface

// File: rtl/jtframe_ps2_tx.sv
// Purpose : sends one command byte from host to a PS/2 device (inhibit, start, 8 data, odd parity, stop, ack).
// Latency : INHIBIT_CYC + START_CYC clk cycles, then 11 device clocks; done/error one cycle after the deciding event.
// Backpressure: busy=1 for the whole transfer; tx_start while busy is ignored.
// Ports   : clk, rst (async active-high); ps2_clk/ps2_data sensed lines; ps2_clk_oe/ps2_data_oe
//           open-collector pull-downs (1 = drive low); host: jtframe_ps2_tx_if slave modport.
module jtframe_ps2_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int START_CYC   = 50,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe,
  jtframe_ps2_tx_if.slave host
);

  localparam int PMAX = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int CW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, RECOVER
  } state_t;

  state_t         state_q;
  logic [1:0]     clk_sync_q, data_sync_q;
  logic           clk_prev_q;
  logic [7:0]     data_q;
  logic           par_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     idx_q;
  logic [TW-1:0]  to_q, to_d;
  logic           clk_oe_q, data_oe_q, busy_q, done_q, error_q;
  logic           fall, timeout_hit;

  // Saturating transfer timer; the limit is checked on the value it is about
  // to take so the error lands exactly TIMEOUT_CYC cycles after acceptance.
  always_comb begin
    to_d        = (to_q == TW'(TIMEOUT_CYC)) ? to_q : to_q + TW'(1);
    timeout_hit = (to_d == TW'(TIMEOUT_CYC));
    fall        = clk_prev_q & ~clk_sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_q      <= '0;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      to_q        <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      if (state_q != IDLE) to_q <= to_d;

      if (state_q != IDLE && timeout_hit) begin
        // busy stays high through the error cycle; IDLE drops it next cycle
        state_q   <= IDLE;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        error_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            // busy_q is still high in the done/error cycle, so a request
            // arriving then is dropped like any other request while busy
            if (host.tx_start && !busy_q) begin
              data_q   <= host.tx_data;
              par_q    <= ~^host.tx_data;
              to_q     <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              clk_oe_q <= 1'b1;
              state_q  <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
              cnt_q     <= '0;
              data_oe_q <= 1'b1;
              state_q   <= START;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          START: begin
            if (cnt_q == CW'(START_CYC - 1)) begin
              clk_oe_q <= 1'b0;
              idx_q    <= '0;
              state_q  <= SHIFT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          SHIFT: begin
            // idx_q counts falling edges already seen: 0..7 data, 8 parity, 9 stop
            if (fall) begin
              idx_q <= idx_q + 4'd1;
              if (idx_q < 4'd8) begin
                data_oe_q <= ~data_q[idx_q[2:0]];
              end else if (idx_q == 4'd8) begin
                data_oe_q <= ~par_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end
          ACK: begin
            if (fall) begin
              if (!data_sync_q[1]) begin
                state_q <= RECOVER;
              end else begin
                error_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          RECOVER: begin
            if (clk_sync_q[1] && data_sync_q[1]) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.error  = error_q;

endmodule

// File: tb/tb_jtframe_ps2_tx.sv
module tb_jtframe_ps2_tx;
  localparam int INH  = 200;
  localparam int STC  = 20;
  localparam int TO   = 4000;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_w, ps2_data_w;
  assign ps2_clk_w  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_w = ~(ps2_data_oe | dev_data_low);

  jtframe_ps2_tx_if host_if();

  jtframe_ps2_tx #(.INHIBIT_CYC(INH), .START_CYC(STC), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .host        (host_if)
  );

  int assertions = 0;
  int failures   = 0;
  int dev_edges  = 0;
  int done_cnt = 0, err_cnt = 0, both_bad = 0, busy_bad = 0, len_bad = 0;
  logic prev_pulse = 1'b0;

  // Pulse bookkeeping, sampled away from the active edge
  always @(negedge clk) begin
    if (host_if.done)  done_cnt++;
    if (host_if.error) err_cnt++;
    if (host_if.done && host_if.error) both_bad++;
    if ((host_if.done || host_if.error) && !host_if.busy) busy_bad++;
    if ((host_if.done || host_if.error) && prev_pulse) len_bad++;
    prev_pulse = host_if.done | host_if.error;
  end

  // Expected frame as the device sees it: d0..d7, odd parity, stop
  function automatic logic [9:0] frame(input logic [7:0] d);
    logic [9:0] f;
    f[7:0] = d;
    f[8]   = ($countones(d) % 2 == 0);
    f[9]   = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    host_if.tx_data  = d;
    host_if.tx_start = 1'b1;
    @(posedge clk); #1;
    host_if.tx_start = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks 10 bits, then ack clock
  task automatic device(input bit ack, output logic [9:0] bits);
    int n;
    n = 0;
    bits = 'x;
    dev_edges = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 2 * TO) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2 * TO) begin
      assertions++; failures++;
      $display("FAIL dev_start: no request-to-send within %0d cycles", 2 * TO);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      dev_edges++;
      repeat (HALF) @(posedge clk);
      #1 bits[i] = ps2_data_w;
      dev_clk_low = 1'b0;
    end
    repeat (HALF / 2) @(posedge clk);
    #1 if (ack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(posedge clk);
    #1 dev_clk_low = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 dev_clk_low = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 dev_data_low = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    while (!host_if.done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    seen = host_if.done;
  endtask

  task automatic test_reset();
    #12;
    assertions++;
    if ({ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_in: outputs %b expected 00000",
               {ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.error});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    assertions++;
    if ({ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_out: outputs %b expected 00000",
               {ps2_clk_oe, ps2_data_oe, host_if.busy, host_if.done, host_if.error});
    end
  endtask

  task automatic test_ed();
    logic [9:0] bits;
    int n, d0;
    bit seen;
    d0 = done_cnt;
    send(8'hED);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 2 * INH) begin n++; @(posedge clk); #1; end
    assertions++;
    if (n !== INH) begin failures++; $display("FAIL ed_inhibit: %0d cycles expected %0d", n, INH); end
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 2 * STC) begin n++; @(posedge clk); #1; end
    assertions++;
    if (n !== STC) begin failures++; $display("FAIL ed_start: %0d cycles expected %0d", n, STC); end
    device(1'b1, bits);
    assertions++;
    if (bits !== 10'b11_11101101) begin
      failures++; $display("FAIL ed_frame: got %b expected %b", bits, 10'b11_11101101);
    end
    wait_done(seen);
    assertions++;
    if (!seen || host_if.busy !== 1'b1) begin
      failures++; $display("FAIL ed_done: seen=%0b busy=%b expected seen=1 busy=1", seen, host_if.busy);
    end
    @(posedge clk); #1;
    assertions++;
    if (host_if.busy !== 1'b0 || host_if.done !== 1'b0) begin
      failures++; $display("FAIL ed_busy_fall: busy=%b done=%b expected 0 0", host_if.busy, host_if.done);
    end
    assertions++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ed_done_cnt: %0d expected 1", done_cnt - d0); end
  endtask

  task automatic xfer_check(input string name, input logic [7:0] d);
    logic [9:0] bits;
    int d0;
    bit seen;
    d0 = done_cnt;
    send(d);
    device(1'b1, bits);
    wait_done(seen);
    repeat (2) @(posedge clk); #1;
    assertions++;
    if (bits !== frame(d)) begin
      failures++; $display("FAIL %s_frame: byte %h got %b expected %b", name, d, bits, frame(d));
    end
    assertions++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL %s_done: %0d pulses expected 1", name, done_cnt - d0); end
  endtask

  task automatic test_zero();
    xfer_check("zero", 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      xfer_check("rand", d);
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'($urandom));
    device(1'b0, bits);
    repeat (5) @(posedge clk); #1;
    assertions++;
    if (err_cnt - e0 !== 1) begin failures++; $display("FAIL nack_err: %0d pulses expected 1", err_cnt - e0); end
    assertions++;
    if (done_cnt - d0 !== 0) begin failures++; $display("FAIL nack_done: %0d pulses expected 0", done_cnt - d0); end
    assertions++;
    if ({ps2_clk_oe, ps2_data_oe, host_if.busy} !== 3'b000) begin
      failures++; $display("FAIL nack_lines: oe/busy %b expected 000", {ps2_clk_oe, ps2_data_oe, host_if.busy});
    end
  endtask

  task automatic test_timeout();
    int n, d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    host_if.tx_data = 8'($urandom);
    host_if.tx_start = 1'b1;
    @(posedge clk); #1;
    host_if.tx_start = 1'b0;
    n = 0;
    while (!host_if.error && n < 2 * TO) begin @(posedge clk); #1; n++; end
    assertions++;
    if (n !== TO) begin failures++; $display("FAIL timeout_cyc: error after %0d cycles expected %0d", n, TO); end
    assertions++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      failures++; $display("FAIL timeout_lines: oe %b expected 00", {ps2_clk_oe, ps2_data_oe});
    end
    repeat (2) @(posedge clk); #1;
    assertions++;
    if (done_cnt - d0 !== 0 || host_if.busy !== 1'b0) begin
      failures++; $display("FAIL timeout_idle: done=%0d busy=%b expected 0 0", done_cnt - d0, host_if.busy);
    end
  endtask

  task automatic test_ignore();
    logic [9:0] bits;
    logic [7:0] d;
    int d0;
    bit seen;
    d = 8'($urandom_range(0, 254));
    d0 = done_cnt;
    send(d);
    fork
      device(1'b1, bits);
      begin
        repeat (INH + STC + 300) @(posedge clk);
        #1 host_if.tx_data = 8'hFF;
        host_if.tx_start = 1'b1;
        @(posedge clk); #1 host_if.tx_start = 1'b0;
      end
    join
    wait_done(seen);
    repeat (2) @(posedge clk); #1;
    assertions++;
    if (bits !== frame(d)) begin failures++; $display("FAIL ignore_frame: got %b expected %b", bits, frame(d)); end
    assertions++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ignore_done: %0d pulses expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    logic [7:0] d;
    int d0, e0, n;
    d = 8'($urandom) & 8'hEF;   // d4 = 0 so data is pulled low after edge 5
    d0 = done_cnt; e0 = err_cnt;
    send(d);
    fork
      device(1'b1, bits);
      begin
        n = 0;
        while (dev_edges < 5 && n < 4 * TO) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        #3;
        assertions++;
        if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rst_pre: data_oe=%b expected 1", ps2_data_oe); end
        rst = 1'b1;
        #1;
        assertions++;
        if ({ps2_clk_oe, ps2_data_oe, host_if.busy} !== 3'b000) begin
          failures++; $display("FAIL rst_async: oe/busy %b expected 000", {ps2_clk_oe, ps2_data_oe, host_if.busy});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (5) @(posedge clk); #1;
    assertions++;
    if (done_cnt != d0 || err_cnt != e0) begin
      failures++; $display("FAIL rst_pulses: done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    xfer_check("after_rst", 8'($urandom));
  endtask

  task automatic test_pulse_rules();
    assertions++;
    if (both_bad !== 0) begin failures++; $display("FAIL rule_both: %0d cycles expected 0", both_bad); end
    assertions++;
    if (busy_bad !== 0) begin failures++; $display("FAIL rule_busy: %0d cycles expected 0", busy_bad); end
    assertions++;
    if (len_bad !== 0) begin failures++; $display("FAIL rule_len: %0d cycles expected 0", len_bad); end
  endtask

  initial begin
    host_if.tx_data  = 8'h00;
    host_if.tx_start = 1'b0;
    test_reset();
    test_ed();
    test_zero();
    test_nack();
    test_timeout();
    test_ignore();
    test_reset_mid();
    test_random();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/jtframe_ps2_tx.md
JTFRAME_PS2_TX -- requirements
Module: jtframe_ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000; clk cycles that ps2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter START_CYC, default 50; clk cycles with data and clock both low before the clock is released.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 750000; maximum clk cycles per transfer, counted from tx_start acceptance (15 ms at 50 MHz).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port ps2_clk  input  1  sensed PS/2 clock line (open-collector, pulled high).
REQ-007 SHALL have port ps2_data  input  1  sensed PS/2 data line.
REQ-008 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-009 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-010 SHALL have port tx_data  input  8  command byte to send to the device (e.g. 8'hED LED command).
REQ-011 SHALL have port tx_start  input  1  one-cycle request; tx_data is sampled in the same cycle.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse; device acknowledged the byte.
REQ-014 SHALL have port error  output  1  one-cycle pulse; missing ack or timeout.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers; a falling edge SHALL be a synchronized clock going 1->0.
REQ-016 SHALL use states IDLE, INHIBIT, START, SHIFT, ACK, RECOVER.
REQ-017 IDLE: busy=0 and both OE=0; tx_start=1 SHALL latch tx_data, compute odd parity (~^tx_data), clear the timeout counter, and move to INHIBIT on the next clock.
REQ-018 A tx_start pulse while busy=1 SHALL be ignored; latched data SHALL be unaffected.
REQ-019 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYC cycles, then go to START.
REQ-020 START: ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0) for START_CYC cycles; then ps2_clk_oe=0 and go to SHIFT with bit index 0.
REQ-021 SHIFT: on each device falling edge, drive the next bit: edges 1-8 drive d0..d7 (LSB first), edge 9 drives parity, edge 10 drives stop (ps2_data_oe=0).
REQ-022 A bit value of 1 SHALL release data (oe=0) and a value of 0 SHALL pull data low (oe=1); data SHALL be changed only in the cycle after a detected falling edge.
REQ-023 After edge 10, go to ACK.
REQ-024 ACK: on the next falling edge, sample synchronized ps2_data; 0 SHALL go to RECOVER, and 1 SHALL pulse error and go to IDLE.
REQ-025 RECOVER: wait for both synchronized lines to be high, then pulse done and go to IDLE.
REQ-026 If the timeout counter reaches TIMEOUT_CYC in any non-IDLE state, the block SHALL release both OE, pulse error, and go to IDLE in the same transition.
REQ-027 done and error SHALL never be asserted together; each SHALL last exactly one cycle.
REQ-028 busy SHALL be 1 in every state except IDLE, including the cycle in which done or error pulses.
REQ-029 Falling edges seen in INHIBIT or START (device glitch) SHALL be ignored.
REQ-030 The bit index SHALL be 4 bits wide and SHALL never wrap past 10.
REQ-031 The timeout counter SHALL saturate and SHALL be sized to hold TIMEOUT_CYC.

Reset
REQ-032 While rst=1, the block SHALL asynchronously enter IDLE with ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, and synchronizers set to 1.
REQ-033 Reset asserted mid-transfer SHALL release both lines immediately, without waiting for a clock, and SHALL emit no done or error pulse.

Verification
REQ-034 Send 8'hED with a device model clocking at 12.5 kHz that acks -> INHIBIT lasts 5000 cycles; serial bits are 0,1,0,1,1,0,1,1,1; parity=1; stop=1; done pulses once and busy falls in the next cycle.
REQ-035 Send 8'h00 -> parity bit=1; data is released only for parity and stop; done pulses.
REQ-036 Device model does not ack (data high at edge 11) -> error pulses once; done stays 0; both OE=0.
REQ-037 Device model never clocks -> error at exactly TIMEOUT_CYC cycles after tx_start; both lines are released.
REQ-038 Second tx_start during SHIFT with 8'hFF -> ignored; the line carries only the original byte.
REQ-039 rst asserted at edge 5 -> both OE=0 before the next clk edge; busy=0; a new tx_start after reset completes normally.
